// File: rtl/tail_light_sched.sv
// Tail-light sequencer: left/right sweep, hazard blink and brake overlay.
// Lamps decode only registered state, so every input reaches the lamps one edge later.
module tail_light_sched #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic left,
    input  logic right,
    input  logic hazard,
    input  logic brake,
    output logic la,
    output logic lb,
    output logic lc,
    output logic ra,
    output logic rb,
    output logic rc,
    output logic busy
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLeft,
        StRight,
        StHaz
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      phase_q, phase_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic            brake_q;

    logic            tick;
    logic            haz_req;
    logic            left_req;
    logic            right_req;
    logic            same_req;
    logic [2:0]      lamp_l;
    logic [2:0]      lamp_r;

    assign tick      = (pre_q == PRE_MAX);
    assign haz_req   = hazard | (left & right);
    assign left_req  = left & ~right & ~hazard;
    assign right_req = right & ~left & ~hazard;
    assign same_req  = (state_q == StLeft) ? left_req : right_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            phase_q <= 3'd1;
            pre_q   <= '0;
            brake_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pre_q   <= pre_d;
            brake_q <= brake;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pre_d   = tick ? '0 : pre_q + 1'b1;

        case (state_q)
            StIdle: begin
                pre_d   = '0;
                phase_d = 3'd1;
                if (haz_req) begin
                    state_d = StHaz;
                end else if (left_req) begin
                    state_d = StLeft;
                end else if (right_req) begin
                    state_d = StRight;
                end
            end

            StLeft, StRight: begin
                if (haz_req) begin
                    state_d = StHaz;
                    phase_d = 3'd1;
                    pre_d   = '0;
                end else if (phase_q < 3'd1 || phase_q > 3'd4) begin
                    state_d = StIdle;
                    phase_d = 3'd1;
                    pre_d   = '0;
                end else if (tick) begin
                    if (phase_q != 3'd4) begin
                        phase_d = phase_q + 3'd1;
                    end else if (same_req) begin
                        // Opposite-side request is ignored here; only IDLE picks it up.
                        phase_d = 3'd1;
                    end else begin
                        state_d = StIdle;
                        phase_d = 3'd1;
                        pre_d   = '0;
                    end
                end
            end

            StHaz: begin
                if (phase_q != 3'd1 && phase_q != 3'd2) begin
                    state_d = StIdle;
                    phase_d = 3'd1;
                    pre_d   = '0;
                end else if (tick) begin
                    if (phase_q == 3'd1) begin
                        phase_d = 3'd2;
                    end else if (haz_req) begin
                        phase_d = 3'd1;
                    end else begin
                        state_d = StIdle;
                        phase_d = 3'd1;
                        pre_d   = '0;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                phase_d = 3'd1;
                pre_d   = '0;
            end
        endcase
    end

    // Lamp vectors are ordered {inner, middle, outer}.
    always_comb begin
        lamp_l = 3'b000;
        lamp_r = 3'b000;
        case (state_q)
            StIdle: begin
                if (brake_q) begin
                    lamp_l = 3'b111;
                    lamp_r = 3'b111;
                end
            end
            StLeft: begin
                case (phase_q)
                    3'd1:    lamp_l = 3'b100;
                    3'd2:    lamp_l = 3'b110;
                    3'd3:    lamp_l = 3'b111;
                    default: lamp_l = 3'b000;
                endcase
                if (brake_q) begin
                    lamp_r = 3'b111;
                end
            end
            StRight: begin
                case (phase_q)
                    3'd1:    lamp_r = 3'b100;
                    3'd2:    lamp_r = 3'b110;
                    3'd3:    lamp_r = 3'b111;
                    default: lamp_r = 3'b000;
                endcase
                if (brake_q) begin
                    lamp_l = 3'b111;
                end
            end
            StHaz: begin
                if (phase_q == 3'd1) begin
                    lamp_l = 3'b111;
                    lamp_r = 3'b111;
                end
            end
            default: begin
                lamp_l = 3'b000;
                lamp_r = 3'b000;
            end
        endcase
    end

    assign la   = lamp_l[2];
    assign lb   = lamp_l[1];
    assign lc   = lamp_l[0];
    assign ra   = lamp_r[2];
    assign rb   = lamp_r[1];
    assign rc   = lamp_r[0];
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_tail_light_sched.sv
// Bench for tail_light_sched: directed scenarios then random input segments,
// checked against an elapsed-time model of the lamp sequences.
module tb_tail_light_sched;

    localparam int TD     = 4;
    localparam int MIdle  = 0;
    localparam int MLeft  = 1;
    localparam int MRight = 2;
    localparam int MHaz   = 3;

    logic clk = 1'b0;
    logic reset;
    logic left, right, hazard, brake;
    logic la, lb, lc, ra, rb, rc, busy;

    int   total = 0;
    int   bad   = 0;

    // Model: current mode, cycles elapsed since the sequence (re)started, sampled brake.
    int   m_mode;
    int   m_t;
    logic m_brake;

    tail_light_sched #(
        .TICK_DIV(TD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .left  (left),
        .right (right),
        .hazard(hazard),
        .brake (brake),
        .la    (la),
        .lb    (lb),
        .lc    (lc),
        .ra    (ra),
        .rb    (rb),
        .rc    (rc),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] model_out();
        logic [2:0] ls;
        logic [2:0] rs;
        logic [2:0] sweep;
        int         step;
        int         n;
        ls    = 3'b000;
        rs    = 3'b000;
        step  = m_t / TD;
        n     = (step >= 3) ? 0 : step + 1;
        sweep = {(n >= 1), (n >= 2), (n >= 3)};
        if (m_mode == MLeft) begin
            ls = sweep;
            if (m_brake) rs = 3'b111;
        end else if (m_mode == MRight) begin
            rs = sweep;
            if (m_brake) ls = 3'b111;
        end else if (m_mode == MHaz) begin
            if (step == 0) begin
                ls = 3'b111;
                rs = 3'b111;
            end
        end else if (m_brake) begin
            ls = 3'b111;
            rs = 3'b111;
        end
        return {(m_mode != MIdle), ls, rs};
    endfunction

    task automatic model_edge(input logic l, input logic r, input logic h, input logic b);
        logic hz, lo, ro, same;
        hz   = h | (l & r);
        lo   = l & ~r & ~h;
        ro   = r & ~l & ~h;
        same = (m_mode == MLeft) ? lo : ro;
        case (m_mode)
            MIdle: begin
                m_t = 0;
                if (hz)      m_mode = MHaz;
                else if (lo) m_mode = MLeft;
                else if (ro) m_mode = MRight;
            end
            MLeft, MRight: begin
                if (hz) begin
                    m_mode = MHaz;
                    m_t    = 0;
                end else if (m_t == 4 * TD - 1) begin
                    m_t = 0;
                    if (!same) m_mode = MIdle;
                end else begin
                    m_t = m_t + 1;
                end
            end
            default: begin
                if (m_t == 2 * TD - 1) begin
                    m_t = 0;
                    if (!hz) m_mode = MIdle;
                end else begin
                    m_t = m_t + 1;
                end
            end
        endcase
        m_brake = b;
    endtask

    task automatic check(input string tag, input logic [6:0] expv);
        logic [6:0] obs;
        obs   = {busy, la, lb, lc, ra, rb, rc};
        total = total + 1;
        assert (obs === expv)
        else begin
            bad = bad + 1;
            $error("FAIL %s: observed busy/lamps=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, take the edge, then compare just after it.
    task automatic cyc(input logic l, input logic r, input logic h, input logic b);
        left   = l;
        right  = r;
        hazard = h;
        brake  = b;
        @(posedge clk);
        model_edge(l, r, h, b);
        #1;
        check("model", model_out());
    endtask

    // Asynchronous reset pulse starting mid-cycle, held across one edge.
    task automatic rst_pulse();
        reset = 1'b0;
        #1;
        m_mode  = MIdle;
        m_t     = 0;
        m_brake = 1'b0;
        check("reset_async", 7'b0);
        @(posedge clk);
        #1;
        check("reset_hold", 7'b0);
        reset = 1'b1;
    endtask

    initial begin
        logic [6:0] e;
        int         seg;
        logic       rl, rr, rh, rbk;

        reset   = 1'b0;
        left    = 1'b0;
        right   = 1'b0;
        hazard  = 1'b0;
        brake   = 1'b0;
        m_mode  = MIdle;
        m_t     = 0;
        m_brake = 1'b0;
        #2;
        check("reset_init", 7'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Left held: la, la/lb, la/lb/lc, dark, then la again.
        for (int i = 1; i <= 17; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            case (i)
                1, 17:   e = 7'b1_100_000;
                5:       e = 7'b1_110_000;
                9:       e = 7'b1_111_000;
                13:      e = 7'b1_000_000;
                default: e = model_out();
            endcase
            check("left_held", e);
        end

        // Single-cycle left pulse runs one full sweep then idles.
        rst_pulse();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= 17; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("left_pulse_idle", 7'b0);

        // Hazard preempts a left sweep during phase 2.
        rst_pulse();
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("haz_preempt", 7'b1_111_111);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("haz_drop_idle", 7'b0);

        // Left and right together from IDLE behave as hazard.
        rst_pulse();
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("lr_haz", 7'b1_111_111);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Brake during a right sweep, then during hazard.
        rst_pulse();
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("brake_right", 7'b1_111_110);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("brake_haz_on", 7'b1_111_111);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("brake_haz_off", 7'b1_000_000);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("brake_idle", 7'b0_111_111);

        // Reset during left phase 3, left still high afterwards.
        rst_pulse();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("left_ph3", 7'b1_111_000);
        rst_pulse();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_resume", 7'b1_100_000);

        // Random input segments with occasional resets.
        for (int s = 0; s < 300; s++) begin
            rl  = ($urandom_range(0, 2) == 0);
            rr  = ($urandom_range(0, 2) == 0);
            rh  = ($urandom_range(0, 9) == 0);
            rbk = ($urandom_range(0, 3) == 0);
            seg = $urandom_range(1, 20);
            if ($urandom_range(0, 49) == 0) rst_pulse();
            for (int c = 0; c < seg; c++) cyc(rl, rr, rh, rbk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
